ahb_slave_regbank: RTL
======================

# ahb_slave_regbank

AHB-Lite responder terminating one port of the interconnect: a bank of DEPTH 32-bit registers with byte/halfword/word access, programmable wait states and a two-cycle ERROR response. It sits behind an interconnect master port and is the endpoint that the master port selects. HSEL comes from that port's address decode; HREADYOUT/HRESP/HRDATA feed its return path.

## Interface
- ADDR_WIDTH, 32, HADDR width.
- DEPTH, 64, number of 32-bit registers; word index is HADDR[$clog2(DEPTH)+1:2].
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15).
- HCLK  in  1  bus clock; all state on rising edge.
- HRESET  in  1  reset. One clock; reset is asynchronous and active-high.
- HSEL  in  1  slave select from the interconnect.
- HADDR  in  ADDR_WIDTH  byte address.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; larger values are errors.
- HBURST, HPROT, HMASTLOCK  in  3/4/1  accepted and ignored.
- HTRANS  in  2  IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3.
- HWDATA  in  32  write data, sampled in data phase.
- HREADY  in  1  bus-level ready (combined HREADY from the interconnect).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.

## Operation
- Accept: on an edge where HSEL & HREADY & HTRANS[1], register addr_q, size_q and write_q, and set err_q.
- err_q is set when any of these holds: word index ≥ DEPTH; HSIZE > 2; half access with HADDR[0] = 1; word access with HADDR[1:0] ≠ 0.
- IDLE/BUSY transfers, or HSEL = 0 with HREADY = 1, are not accepted and give a zero-wait OKAY.
- State machine:
  - IDLE: HREADYOUT = 1, HRESP = 0.
  - WAIT: HREADYOUT = 0; counter loaded with WAIT_STATES−1 and decremented each cycle; moves to ACCESS at 0.
  - ACCESS: HREADYOUT = 1; read data valid; write commits on the closing edge.
  - ERR1: HRESP = 1, HREADYOUT = 0.
  - ERR2: HRESP = 1, HREADYOUT = 1.
- Transitions:
  - On accept with err → ERR1.
  - On accept with WAIT_STATES = 0 → ACCESS.
  - On accept otherwise → WAIT.
  - ERR1 → ERR2 unconditionally.
  - From ACCESS or ERR2, a new accept in the same cycle (pipelined address phase) goes straight to the next transfer's state. Without one, go to IDLE.
- Write strobes:
  - byte: lane addr_q[1:0];
  - half: lanes {addr_q[1],0} and {addr_q[1],1};
  - word: all 4 lanes.
  - Only strobed bytes of mem[idx] are updated from HWDATA.
- Read: HRDATA = mem[idx_q] (full word, unshifted) in ACCESS. HRDATA = 0 in all other states.
- An erroring write never modifies memory.
- Register contents reset to 0.

## Timing
- Reset values: HREADYOUT = 1, HRESP = 0, HRDATA = 0, state = IDLE, all registers 0. Reset mid-transfer aborts it, and the pending write is dropped.
- OKAY latency: the data phase is 1 + WAIT_STATES cycles after the address phase.
- Back-to-back: a write followed by a read of the same address returns the new data, because the write commits at the end of its ACCESS cycle, before the read's ACCESS.
- HWDATA is sampled only at the ACCESS closing edge. The master holds it through WAIT.
- ERROR is always exactly 2 cycles, independent of WAIT_STATES.
- Accept during ERR2 is legal: AHB lets the master cancel, and an IDLE HTRANS then yields IDLE.
- HSEL deasserting during WAIT has no effect; the data phase completes.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS and HSIZE encodings;
  - HRESP_OKAY/HRESP_ERROR;
  - the state enum typedef {IDLE, WAIT, ACCESS, ERR1, ERR2}.
- Sub-module ahb_wstrb_gen is combinational: (HSIZE, HADDR[1:0]) → 4-bit strobe plus a misalign flag. It is reusable by other AHB responders.
- Top level holds: FSM, wait counter, address/control registers, the register array.

## Test plan
- Reset released, idle bus: HREADYOUT = 1, HRESP = 0, HRDATA = 0; a word read of 0x00 returns 0x00000000.
- WAIT_STATES = 2: word write 0xDEADBEEF to 0x04, then read 0x04 → HREADYOUT low 2 cycles each; the read returns 0xDEADBEEF. Cover back-to-back, no idle between.
- Byte write 0xAA to 0x09 over word 0x11223344 → readback of 0x08 = 0x1122AA44. Half write 0x5566 to 0x0A → 0x5566AA44.
- Misaligned word write to 0x02 → HRESP = 1, HREADYOUT = 0, then 1. Word 0x00 is unchanged on readback.
- DEPTH = 64, read 0x100 (index 64) → two-cycle ERROR. A following read of 0xFC is OKAY.
- HRESET asserted during the WAIT of a write to 0x10 → outputs return to reset values immediately; readback of 0x10 = 0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and responder state type.
// Imported by the register bank and its helpers.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

endpackage

// File: rtl/ahb_wstrb_gen.sv
// Byte-lane strobe and alignment check for one AHB transfer.
// Unsupported sizes give no strobes; the caller flags them.
module ahb_wstrb_gen
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb,
    output logic       misalign
);

    // Decode size and low address bits into byte lanes
    always_comb begin
        strb     = 4'b0000;
        misalign = 1'b0;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            HSIZE_WORD: begin
                strb     = 4'b1111;
                misalign = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_slave_regbank.sv
// AHB-Lite register bank responder with wait states
// and a two-cycle ERROR response.
module ahb_slave_regbank
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HMASTLOCK,
    input  logic [1:0]            HTRANS,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(DEPTH);

    state_t        state;
    logic [IW-1:0] idx_q;
    logic [3:0]    strb_q;
    logic          write_q;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH];

    logic       accept;
    logic       err_a;
    logic       misalign;
    logic [3:0] strb_a;
    logic       unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    ahb_wstrb_gen u_wstrb (
        .size     (HSIZE),
        .addr_lo  (HADDR[1:0]),
        .strb     (strb_a),
        .misalign (misalign)
    );

    // Only IDLE, ACCESS and ERR2 can take a new address phase
    assign accept = HSEL & HREADY & HTRANS[1]
                  & (state == IDLE || state == ACCESS || state == ERR2);

    assign err_a = (HADDR[ADDR_WIDTH-1:2] >= DEPTH_W)
                 | (HSIZE > HSIZE_WORD)
                 | misalign;

    // Transfer FSM with registered ready/response
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            cnt       <= 4'd0;
            idx_q     <= '0;
            strb_q    <= 4'b0000;
            write_q   <= 1'b0;
        end else if (accept) begin
            idx_q   <= HADDR[IW+1:2];
            strb_q  <= strb_a;
            write_q <= HWRITE;
            cnt     <= 4'(WAIT_STATES - 1);
            if (err_a) begin
                state     <= ERR1;
                HREADYOUT <= 1'b0;
                HRESP     <= HRESP_ERROR;
            end else if (WAIT_STATES == 0) begin
                state     <= ACCESS;
                HREADYOUT <= 1'b1;
                HRESP     <= HRESP_OKAY;
            end else begin
                state     <= WAIT;
                HREADYOUT <= 1'b0;
                HRESP     <= HRESP_OKAY;
            end
        end else begin
            case (state)
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= ACCESS;
                        HREADYOUT <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ERR1: begin
                    state     <= ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                default: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Strobed write commits on the closing edge of ACCESS
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (state == ACCESS && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HRDATA = (state == ACCESS) ? mem[idx_q] : 32'h0;

endmodule
